// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
// LOADER_CSUM_EN enables the trailing checksum byte.
package uart_loader_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StHdr,
      StTgt,
      StLenH,
      StLenL,
      StData,
      StCsum,
      StDone,
      StErr
   } ld_state_e;

   typedef enum logic [1:0] {
      RxIdle,
      RxStart,
      RxData,
      RxStop
   } rx_state_e;

   localparam logic [7:0] HDR_BYTE = 8'hA5;
   localparam logic [7:0] TGT_IMEM = 8'h00;
   localparam logic [7:0] TGT_DMEM = 8'h01;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, mid-bit sampling, glitch-rejecting start
// detection and one-cycle byte_vld / frame_err strobes.
module uart_rx_byte
   import uart_loader_pkg::*;
#(
   parameter int unsigned CLK_HZ = 10_000_000,
   parameter int unsigned BAUD   = 115200
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       i_rx,
   output logic       o_byte_vld,
   output logic [7:0] o_byte_data,
   output logic       o_frame_err
);

   localparam int unsigned DIV  = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int unsigned HALF = DIV / 2;
   localparam int unsigned CW   = $clog2(DIV + 1);

   logic [1:0]    r_sync;
   logic          r_rx_prev;
   rx_state_e     r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_byte_vld;
   logic          r_frame_err;
   logic          w_rx;

   assign w_rx        = r_sync[1];
   assign o_byte_vld  = r_byte_vld;
   assign o_byte_data = r_shift;
   assign o_frame_err = r_frame_err;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         // Synchronizer resets to the idle level so reset release cannot fake a start edge.
         r_sync      <= 2'b11;
         r_rx_prev   <= 1'b1;
         r_state     <= RxIdle;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_byte_vld  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_sync      <= {r_sync[0], i_rx};
         r_rx_prev   <= w_rx;
         r_byte_vld  <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            RxIdle: begin
               if (r_rx_prev && !w_rx) begin
                  r_state <= RxStart;
                  r_cnt   <= '0;
               end
            end
            RxStart: begin
               if (r_cnt == CW'(HALF - 1)) begin
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_state   <= w_rx ? RxIdle : RxData;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            RxData: begin
               if (r_cnt == CW'(DIV - 1)) begin
                  r_cnt   <= '0;
                  r_shift <= {w_rx, r_shift[7:1]};
                  if (r_bit_idx == 3'd7) begin
                     r_state <= RxStop;
                  end
                  r_bit_idx <= r_bit_idx + 3'd1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            RxStop: begin
               if (r_cnt == CW'(DIV - 1)) begin
                  r_cnt       <= '0;
                  r_byte_vld  <= w_rx;
                  r_frame_err <= !w_rx;
                  r_state     <= RxIdle;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= RxIdle;
         endcase
      end
   end

endmodule

// File: rtl/uart_loader.sv
// Serial program loader: parses A5/target/length/words frames and writes words to imem or dmem.
// Define LOADER_CSUM_EN to require a trailing XOR checksum byte.
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned CLK_HZ = 10_000_000,
   parameter int unsigned BAUD   = 115200,
   parameter int unsigned ADDR_W = 14
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              start,
   input  logic              rx,
   output logic              load_active,
   output logic              cpu_rst,
   output logic              wr_en,
   output logic              wr_sel,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              done,
   output logic              err
);

   localparam int unsigned MAX_N = 2 ** ADDR_W;

   logic              w_byte_vld;
   logic [7:0]        w_byte_data;
   logic              w_frame_err;
   logic              w_start_rise;
   logic [15:0]       w_len;

   ld_state_e         r_state;
   logic              r_start_prev;
   logic              r_load_active;
   logic              r_wr_en;
   logic              r_wr_sel;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [31:0]       r_wr_data;
   logic              r_done;
   logic              r_err;
   logic [7:0]        r_len_h;
   logic [15:0]       r_words_left;
   logic [1:0]        r_bcnt;
`ifdef LOADER_CSUM_EN
   logic [7:0]        r_csum;
`endif

   uart_rx_byte #(
      .CLK_HZ(CLK_HZ),
      .BAUD  (BAUD)
   ) u_rx (
      .clock      (clock),
      .rst_n      (rst_n),
      .i_rx       (rx),
      .o_byte_vld (w_byte_vld),
      .o_byte_data(w_byte_data),
      .o_frame_err(w_frame_err)
   );

   assign w_start_rise = start && !r_start_prev;
   assign w_len        = {r_len_h, w_byte_data};
   assign load_active  = r_load_active;
   assign cpu_rst      = r_load_active;
   assign wr_en        = r_wr_en;
   assign wr_sel       = r_wr_sel;
   assign wr_addr      = r_wr_addr;
   assign wr_data      = r_wr_data;
   assign done         = r_done;
   assign err          = r_err;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= StIdle;
         r_start_prev  <= 1'b0;
         r_load_active <= 1'b0;
         r_wr_en       <= 1'b0;
         r_wr_sel      <= 1'b0;
         r_wr_addr     <= '0;
         r_wr_data     <= '0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
         r_len_h       <= '0;
         r_words_left  <= '0;
         r_bcnt        <= '0;
`ifdef LOADER_CSUM_EN
         r_csum        <= '0;
`endif
      end else begin
         r_start_prev <= start;
         r_wr_en      <= 1'b0;
         if (r_wr_en) begin
            r_wr_addr <= r_wr_addr + ADDR_W'(1);
         end
         case (r_state)
            StIdle, StDone, StErr: begin
               if (w_start_rise) begin
                  r_state       <= StHdr;
                  r_load_active <= 1'b1;
                  r_done        <= 1'b0;
                  r_err         <= 1'b0;
                  r_wr_addr     <= '0;
`ifdef LOADER_CSUM_EN
                  r_csum        <= '0;
`endif
               end
            end
            StHdr: begin
               if (w_byte_vld && w_byte_data == HDR_BYTE) begin
                  r_state <= StTgt;
               end
            end
            StTgt: begin
               if (w_byte_vld) begin
                  if (w_byte_data == TGT_IMEM || w_byte_data == TGT_DMEM) begin
                     r_wr_sel <= w_byte_data[0];
                     r_state  <= StLenH;
                  end else begin
                     r_state       <= StErr;
                     r_load_active <= 1'b0;
                     r_err         <= 1'b1;
                  end
               end
            end
            StLenH: begin
               if (w_byte_vld) begin
                  r_len_h <= w_byte_data;
                  r_state <= StLenL;
               end
            end
            StLenL: begin
               if (w_byte_vld) begin
                  r_words_left <= w_len;
                  r_bcnt       <= '0;
                  if (32'(w_len) > MAX_N) begin
                     r_state       <= StErr;
                     r_load_active <= 1'b0;
                     r_err         <= 1'b1;
                  end else if (w_len == 16'd0) begin
`ifdef LOADER_CSUM_EN
                     r_state <= StCsum;
`else
                     r_state       <= StDone;
                     r_load_active <= 1'b0;
                     r_done        <= 1'b1;
`endif
                  end else begin
                     r_state <= StData;
                  end
               end
            end
            StData: begin
               if (w_byte_vld) begin
                  r_wr_data[{r_bcnt, 3'b000} +: 8] <= w_byte_data;
                  r_bcnt                           <= r_bcnt + 2'd1;
`ifdef LOADER_CSUM_EN
                  r_csum <= r_csum ^ w_byte_data;
`endif
                  if (r_bcnt == 2'd3) begin
                     r_wr_en      <= 1'b1;
                     r_words_left <= r_words_left - 16'd1;
                     if (r_words_left == 16'd1) begin
`ifdef LOADER_CSUM_EN
                        r_state <= StCsum;
`else
                        r_state       <= StDone;
                        r_load_active <= 1'b0;
                        r_done        <= 1'b1;
`endif
                     end
                  end
               end
            end
`ifdef LOADER_CSUM_EN
            StCsum: begin
               if (w_byte_vld) begin
                  r_load_active <= 1'b0;
                  if (w_byte_data == r_csum) begin
                     r_state <= StDone;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= StErr;
                     r_err   <= 1'b1;
                  end
               end
            end
`endif
            default: r_state <= StIdle;
         endcase
         // A framing error in any receiving state overrides whatever the byte handling chose.
         if (w_frame_err && r_load_active) begin
            r_state       <= StErr;
            r_load_active <= 1'b0;
            r_err         <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader; sends checksum bytes when LOADER_CSUM_EN is defined.
`timescale 1ns/1ps
module tb_uart_loader;

   localparam int BIT = 87;

   logic        clock;
   logic        rst_n;
   logic        start;
   logic        rx;
   logic        load_active;
   logic        cpu_rst;
   logic        wr_en;
   logic        wr_sel;
   logic [13:0] wr_addr;
   logic [31:0] wr_data;
   logic        done;
   logic        err;

   int n_total = 0;
   int n_bad   = 0;
   int n_wr    = 0;
   int n_byte  = 0;
   logic [13:0] log_addr [0:63];
   logic [31:0] log_data [0:63];
   logic        log_sel  [0:63];

   uart_loader #(
      .CLK_HZ(10_000_000),
      .BAUD  (115200),
      .ADDR_W(14)
   ) dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .start      (start),
      .rx         (rx),
      .load_active(load_active),
      .cpu_rst    (cpu_rst),
      .wr_en      (wr_en),
      .wr_sel     (wr_sel),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .done       (done),
      .err        (err)
   );

   initial clock = 1'b0;
   always #50 clock = ~clock;

   always @(negedge clock) begin
      if (wr_en) begin
         log_addr[n_wr % 64] = wr_addr;
         log_data[n_wr % 64] = wr_data;
         log_sel[n_wr % 64]  = wr_sel;
         n_wr = n_wr + 1;
      end
      if (dut.w_byte_vld) n_byte = n_byte + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total = n_total + 1;
      if (got !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clock);
      rx = 1'b0;
      wait_cyc(BIT);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_cyc(BIT);
      end
      rx = stop_bit;
      wait_cyc(BIT);
      rx = 1'b1;
      wait_cyc(2);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      wait_cyc(3);
      start = 1'b0;
      wait_cyc(2);
   endtask

   // A5 00 0002 {12345678} {DEADBEEF}; XOR of data bytes is 0x2A.
   task automatic send_frame_a(input logic [7:0] csum);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h02, 1'b1);
      send_word(32'h12345678);
      send_word(32'hDEADBEEF);
`ifdef LOADER_CSUM_EN
      send_byte(csum, 1'b1);
`else
      if (csum == 8'hFF) send_byte(8'hFF, 1'b1);
`endif
      wait_cyc(3);
   endtask

   task automatic send_frame_b();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      send_word(32'h00000001);
`ifdef LOADER_CSUM_EN
      send_byte(8'h01, 1'b1);
`endif
      wait_cyc(3);
   endtask

   initial begin
      int base;
      int bbase;
      rst_n = 1'b0;
      start = 1'b0;
      rx    = 1'b1;
      wait_cyc(5);
      check_eq("rst_load_active", 32'(load_active), 32'd0);
      check_eq("rst_cpu_rst", 32'(cpu_rst), 32'd0);
      check_eq("rst_wr_en", 32'(wr_en), 32'd0);
      check_eq("rst_wr_sel", 32'(wr_sel), 32'd0);
      check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
      check_eq("rst_wr_data", wr_data, 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      wait_cyc(5);

      // Basic two-word imem load
      base = n_wr;
      pulse_start();
      check_eq("t1_armed", 32'(load_active), 32'd1);
      check_eq("t1_cpu_rst", 32'(cpu_rst), 32'd1);
      send_frame_a(8'h2A);
      check_eq("t1_nwr", 32'(n_wr - base), 32'd2);
      check_eq("t1_addr0", 32'(log_addr[base % 64]), 32'd0);
      check_eq("t1_data0", log_data[base % 64], 32'h12345678);
      check_eq("t1_addr1", 32'(log_addr[(base + 1) % 64]), 32'd1);
      check_eq("t1_data1", log_data[(base + 1) % 64], 32'hDEADBEEF);
      check_eq("t1_sel", 32'(wr_sel), 32'd0);
      check_eq("t1_done", 32'(done), 32'd1);
      check_eq("t1_err", 32'(err), 32'd0);
      check_eq("t1_inactive", 32'(load_active), 32'd0);

      // Garbage before header, dmem target
      base = n_wr;
      pulse_start();
      check_eq("t2_done_clr", 32'(done), 32'd0);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_frame_b();
      check_eq("t2_nwr", 32'(n_wr - base), 32'd1);
      check_eq("t2_addr", 32'(log_addr[base % 64]), 32'd0);
      check_eq("t2_data", log_data[base % 64], 32'h00000001);
      check_eq("t2_sel", 32'(log_sel[base % 64]), 32'd1);
      check_eq("t2_done", 32'(done), 32'd1);

      // Bad target byte
      base = n_wr;
      pulse_start();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h07, 1'b1);
      wait_cyc(3);
      check_eq("t3_err", 32'(err), 32'd1);
      check_eq("t3_inactive", 32'(load_active), 32'd0);
      check_eq("t3_done", 32'(done), 32'd0);
      check_eq("t3_nwr", 32'(n_wr - base), 32'd0);

      // Framing error on a data byte, then recovery
      base = n_wr;
      pulse_start();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h78, 1'b1);
      send_byte(8'h56, 1'b0);
      wait_cyc(3);
      check_eq("t4_err", 32'(err), 32'd1);
      check_eq("t4_inactive", 32'(load_active), 32'd0);
      send_byte(8'h34, 1'b1);
      send_byte(8'h12, 1'b1);
      check_eq("t4_nwr", 32'(n_wr - base), 32'd0);
      base = n_wr;
      pulse_start();
      check_eq("t4_err_clr", 32'(err), 32'd0);
      send_frame_a(8'h2A);
      check_eq("t4_re_done", 32'(done), 32'd1);
      check_eq("t4_re_nwr", 32'(n_wr - base), 32'd2);
      check_eq("t4_re_data1", log_data[(base + 1) % 64], 32'hDEADBEEF);

      // Short low glitch (~0.3 bit) while waiting for the header
      base  = n_wr;
      pulse_start();
      bbase = n_byte;
      @(negedge clock);
      rx = 1'b0;
      wait_cyc(26);
      rx = 1'b1;
      wait_cyc(300);
      check_eq("t5_nbyte", 32'(n_byte - bbase), 32'd0);
      check_eq("t5_active", 32'(load_active), 32'd1);
      check_eq("t5_err", 32'(err), 32'd0);
      send_frame_b();
      check_eq("t5_done", 32'(done), 32'd1);
      check_eq("t5_nwr", 32'(n_wr - base), 32'd1);

      // Zero-length frame
      base = n_wr;
      pulse_start();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
`ifdef LOADER_CSUM_EN
      send_byte(8'h00, 1'b1);
`endif
      wait_cyc(3);
      check_eq("t6_done", 32'(done), 32'd1);
      check_eq("t6_err", 32'(err), 32'd0);
      check_eq("t6_nwr", 32'(n_wr - base), 32'd0);

      // Length just above 2^ADDR_W
      pulse_start();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h40, 1'b1);
      send_byte(8'h01, 1'b1);
      wait_cyc(3);
      check_eq("t7_err", 32'(err), 32'd1);
      check_eq("t7_inactive", 32'(load_active), 32'd0);

      // Reset asserted mid-word
      base = n_wr;
      pulse_start();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1);
      @(negedge clock);
      rx = 1'b0;
      wait_cyc(300);
      rst_n = 1'b0;
      #1;
      check_eq("t8_active", 32'(load_active), 32'd0);
      check_eq("t8_wr_data", wr_data, 32'd0);
      check_eq("t8_err", 32'(err), 32'd0);
      wait_cyc(3);
      rx = 1'b1;
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(BIT * 12);
      check_eq("t8_nwr", 32'(n_wr - base), 32'd0);
      check_eq("t8_idle", 32'(load_active), 32'd0);

`ifdef LOADER_CSUM_EN
      // Wrong checksum: words still written, err raised
      base = n_wr;
      pulse_start();
      send_frame_a(8'h2B);
      check_eq("t9_err", 32'(err), 32'd1);
      check_eq("t9_done", 32'(done), 32'd0);
      check_eq("t9_nwr", 32'(n_wr - base), 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
